// File: rtl/game_display_if.sv
// Bundle between the reaction game FSM (master) and the seven-segment display driver (slave).
interface game_display_if;
    logic [3:0] counter;
    logic [1:0] state_in;
    logic       led0;
    logic       led1;
    logic       led2;
    logic       led3;
    logic       led4;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    modport master (
        output counter, state_in, led0, led1, led2, led3, led4,
        input  seg, an, dp
    );

    modport slave (
        input  counter, state_in, led0, led1, led2, led3, led4,
        output seg, an, dp
    );
endinterface

// File: rtl/game_display.sv
// Multiplexed 4-digit seven-segment driver for the reaction game: shows value, lives and status,
// freezes the stopped value and blinks the whole display when the game has ended.
module game_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 12500000
) (
    input  logic          clk,
    input  logic          rst,
    game_display_if.slave io_disp
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_DIV - 1);

    localparam logic [1:0] ST_COUNT = 2'd0;
    localparam logic [1:0] ST_STOP  = 2'd1;
    localparam logic [1:0] ST_WIN   = 2'd2;
    localparam logic [1:0] ST_LOSE  = 2'd3;

    logic [RW-1:0] r_refresh_cnt;
    logic [1:0]    r_digit_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;
    logic [3:0]    r_held;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;
    logic          r_dp;

    logic [3:0]    w_shown;
    logic [2:0]    w_lives;
    logic          w_blink_active;
    logic [6:0]    w_digit_seg;
    logic [3:0]    w_digit_an;
    logic          w_dp;

    function automatic logic [6:0] hexGlyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    always_comb begin
        w_shown        = (io_disp.state_in == ST_WIN || io_disp.state_in == ST_LOSE) ? r_held : io_disp.counter;
        w_lives        = {2'b00, io_disp.led0} + {2'b00, io_disp.led1} + {2'b00, io_disp.led2} + {2'b00, io_disp.led3};
        w_blink_active = (io_disp.state_in == ST_WIN) || (io_disp.state_in == ST_LOSE && io_disp.led4);
        w_dp           = !(r_digit_idx == 2'd3 && io_disp.state_in == ST_WIN);
        w_digit_seg    = 7'h7F;
        w_digit_an     = 4'b1111;
        case (r_digit_idx)
            2'd0: begin
                w_digit_seg = hexGlyph(w_shown);
                w_digit_an  = 4'b1110;
            end
            2'd1: begin
                w_digit_seg = hexGlyph({1'b0, w_lives});
                w_digit_an  = 4'b1101;
            end
            2'd2: begin
                w_digit_seg = 7'h7F;
                w_digit_an  = 4'b1011;
            end
            default: begin
                w_digit_an = 4'b0111;
                case (io_disp.state_in)
                    ST_COUNT: w_digit_seg = 7'h46;
                    ST_STOP:  w_digit_seg = 7'h3F;
                    ST_WIN:   w_digit_seg = 7'h0C;
                    default:  w_digit_seg = 7'h47;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= 2'd0;
        end else if (r_refresh_cnt == REFRESH_MAX) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= r_digit_idx + 2'd1;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
        end
    end

    // Blink phase runs independently of the digit rotation and restarts visible when inactive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (!w_blink_active) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == BLINK_MAX) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held <= 4'd0;
        end else if (io_disp.state_in == ST_STOP) begin
            r_held <= io_disp.counter;
        end
    end

    // Blanking only applies while blinking is active, so leaving the end state is visible on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= 7'h7F;
            r_an  <= 4'b1111;
            r_dp  <= 1'b1;
        end else begin
            r_seg <= w_digit_seg;
            r_an  <= (w_blink_active && !r_blink_on) ? 4'b1111 : w_digit_an;
            r_dp  <= w_dp;
        end
    end

    assign io_disp.seg = r_seg;
    assign io_disp.an  = r_an;
    assign io_disp.dp  = r_dp;

endmodule

// File: tb/tb_game_display.sv
// Self-checking bench for game_display: a cycle model pushes expected outputs to a scoreboard
// queue each cycle, and directed checks cover the scenarios of the reaction-game display.
module tb_game_display;

    localparam int REFRESH_DIV = 4;
    localparam int BLINK_DIV   = 8;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       dp;
    } expT;

    logic clk = 1'b0;
    logic rst = 1'b0;

    game_display_if disp();

    game_display #(
        .REFRESH_DIV(REFRESH_DIV),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io_disp(disp)
    );

    always #5 clk = ~clk;

    logic [6:0] glyphTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    expT scoreboard [$];
    int errorCount = 0;
    int checkCount = 0;

    int         mRefresh;
    int         mDigit;
    int         mBlinkCnt;
    bit         mBlinkOn;
    logic [3:0] mHeld;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mRefresh  = 0;
        mDigit    = 0;
        mBlinkCnt = 0;
        mBlinkOn  = 1'b1;
        mHeld     = 4'd0;
        scoreboard.delete();
    endtask

    // Predicts the next-edge outputs from the model and current inputs, then checks them after the edge.
    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            expT        e;
            expT        popped;
            logic [3:0] shown;
            int         lives;
            bit         active;
            @(negedge clk);
            shown  = (disp.state_in >= 2'd2) ? mHeld : disp.counter;
            lives  = int'(disp.led0) + int'(disp.led1) + int'(disp.led2) + int'(disp.led3);
            active = (disp.state_in == 2'd2) || (disp.state_in == 2'd3 && disp.led4);
            case (mDigit)
                0: e.seg = glyphTab[shown];
                1: e.seg = glyphTab[lives];
                2: e.seg = 7'h7F;
                default: begin
                    case (disp.state_in)
                        2'd0: e.seg = 7'h46;
                        2'd1: e.seg = 7'h3F;
                        2'd2: e.seg = 7'h0C;
                        default: e.seg = 7'h47;
                    endcase
                end
            endcase
            case (mDigit)
                0: e.an = 4'b1110;
                1: e.an = 4'b1101;
                2: e.an = 4'b1011;
                default: e.an = 4'b0111;
            endcase
            if (active && !mBlinkOn) e.an = 4'b1111;
            e.dp = !(mDigit == 3 && disp.state_in == 2'd2);
            scoreboard.push_back(e);

            if (disp.state_in == 2'd1) mHeld = disp.counter;
            if (mRefresh == REFRESH_DIV - 1) begin
                mRefresh = 0;
                mDigit   = (mDigit + 1) % 4;
            end else begin
                mRefresh++;
            end
            if (!active) begin
                mBlinkCnt = 0;
                mBlinkOn  = 1'b1;
            end else if (mBlinkCnt == BLINK_DIV - 1) begin
                mBlinkCnt = 0;
                mBlinkOn  = !mBlinkOn;
            end else begin
                mBlinkCnt++;
            end

            @(posedge clk);
            #1;
            popped = scoreboard.pop_front();
            checkOutput("sb_seg", 32'(disp.seg), 32'(popped.seg));
            checkOutput("sb_an", 32'(disp.an), 32'(popped.an));
            checkOutput("sb_dp", 32'(disp.dp), 32'(popped.dp));
        end
    endtask

    task automatic findDigit(input string tag, input logic [3:0] anWant,
                             output logic [6:0] segSeen, output logic dpSeen);
        bit found;
        found   = 1'b0;
        segSeen = 7'h7F;
        dpSeen  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1);
            if (disp.an == anWant) begin
                found   = 1'b1;
                segSeen = disp.seg;
                dpSeen  = disp.dp;
                break;
            end
        end
        checkOutput({tag, "_found"}, 32'(found), 32'd1);
    endtask

    task automatic setLeds(input logic [3:0] lives, input logic over);
        disp.led0 = lives[0];
        disp.led1 = lives[1];
        disp.led2 = lives[2];
        disp.led3 = lives[3];
        disp.led4 = over;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [6:0] segSeen;
        logic       dpSeen;
        int         run;
        int         cnt10;
        int         cnt30;
        int         blanks;
        bit         seen;

        disp.counter  = 4'd5;
        disp.state_in = 2'd0;
        setLeds(4'b1111, 1'b0);

        // Reset values appear asynchronously, before any clock edge.
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_an", 32'(disp.an), 32'h0F);
        checkOutput("rst_seg", 32'(disp.seg), 32'h7F);
        checkOutput("rst_dp", 32'(disp.dp), 32'd1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        modelReset();

        // Normal scan while counting.
        applyStimulus(1);
        checkOutput("t1_first_an", 32'(disp.an), 32'b1110);
        checkOutput("t1_d0_seg", 32'(disp.seg), 32'h12);
        run = 1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            if (disp.an == 4'b1110) run++;
            else break;
        end
        checkOutput("t1_hold", 32'(run), 32'd4);
        checkOutput("t1_d1_an", 32'(disp.an), 32'b1101);
        checkOutput("t1_d1_seg", 32'(disp.seg), 32'h19);
        findDigit("t1_d2", 4'b1011, segSeen, dpSeen);
        checkOutput("t1_d2_seg", 32'(segSeen), 32'h7F);
        findDigit("t1_d3", 4'b0111, segSeen, dpSeen);
        checkOutput("t1_d3_seg", 32'(segSeen), 32'h46);
        checkOutput("t1_d3_dp", 32'(dpSeen), 32'd1);
        applyStimulus(16);

        // Stop capture followed by a win.
        disp.counter  = 4'd9;
        disp.state_in = 2'd1;
        applyStimulus(1);
        disp.state_in = 2'd2;
        disp.counter  = 4'd3;
        cnt10 = 0;
        cnt30 = 0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1);
            if (disp.seg == 7'h10) cnt10++;
            if (disp.seg == 7'h30) cnt30++;
        end
        checkOutput("t2_held9", 32'(cnt10), 32'd8);
        checkOutput("t2_not3", 32'(cnt30), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1);
            if (disp.dp == 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("t2_dp_found", 32'(seen), 32'd1);
        checkOutput("t2_d3_seg", 32'(disp.seg), 32'h0C);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1);
            if (disp.an != 4'b1111) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("t2_visible_found", 32'(seen), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1);
            if (disp.an == 4'b1111) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("t2_blank_found", 32'(seen), 32'd1);
        run = 1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1);
            if (disp.an == 4'b1111) run++;
            else break;
        end
        checkOutput("t2_blank_len", 32'(run), 32'd8);
        run = 1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1);
            if (disp.an != 4'b1111) run++;
            else break;
        end
        checkOutput("t2_visible_len", 32'(run), 32'd8);

        // Lose with lives remaining: no blanking.
        disp.state_in = 2'd3;
        setLeds(4'b0111, 1'b0);
        blanks = 0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1);
            if (disp.an == 4'b1111) blanks++;
        end
        checkOutput("t3_no_blank", 32'(blanks), 32'd0);
        findDigit("t3_d1", 4'b1101, segSeen, dpSeen);
        checkOutput("t3_d1_seg", 32'(segSeen), 32'h30);
        findDigit("t3_d3", 4'b0111, segSeen, dpSeen);
        checkOutput("t3_d3_seg", 32'(segSeen), 32'h47);

        // Game over blinks; leaving it mid-blank restores the digits on the next edge.
        setLeds(4'b0000, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1);
            if (disp.an == 4'b1111) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("t4_blank_found", 32'(seen), 32'd1);
        applyStimulus(2);
        disp.state_in = 2'd0;
        applyStimulus(1);
        checkOutput("t4_unblank", 32'(disp.an != 4'b1111), 32'd1);
        applyStimulus(8);

        // Asynchronous reset between clock edges, then restart with a cleared held value.
        setLeds(4'b1111, 1'b0);
        applyStimulus(2);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_an", 32'(disp.an), 32'h0F);
        checkOutput("t5_seg", 32'(disp.seg), 32'h7F);
        checkOutput("t5_dp", 32'(disp.dp), 32'd1);
        disp.state_in = 2'd2;
        disp.counter  = 4'd7;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        modelReset();
        applyStimulus(1);
        checkOutput("t5_restart_an", 32'(disp.an), 32'b1110);
        checkOutput("t5_held_zero", 32'(disp.seg), 32'h40);
        applyStimulus(8);

        // Counting sweep through every glyph, including the F to 0 wrap.
        disp.state_in = 2'd0;
        for (int v = 0; v < 16; v++) begin
            disp.counter = 4'(v);
            segSeen = 7'h7F;
            for (int c = 0; c < 4 * REFRESH_DIV; c++) begin
                applyStimulus(1);
                if (disp.an == 4'b1110) segSeen = disp.seg;
            end
            checkOutput($sformatf("t6_d0_%0d", v), 32'(segSeen), 32'(glyphTab[v]));
        end
        disp.counter = 4'd0;
        applyStimulus(4 * REFRESH_DIV);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/game_display.md
# game_display

Multiplexed 4-digit seven-segment driver that sits downstream of the reaction game FSM and consumes its outputs: live counter value, lives LEDs and game state. It time-multiplexes the digits, freezes the value the player stopped on, and blinks the display at game end. Purely a sink; it never feeds back into the game.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit stays selected (≥2).
- BLINK_DIV, 12500000: clock cycles per blink half-period (≥2).

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- counter  in  4  game counter value (0..15)
- state_in  in  2  game state: 0 counting, 1 stop, 2 win, 3 lose
- led0..led3  in  1 each  lives thermometer from game
- led4  in  1  game-over flag (lives exhausted)
- seg  out  7  segment drive {g,f,e,d,c,b,a}, active-low
- an  out  4  digit enables, active-low, an[0] = rightmost
- dp  out  1  decimal point, active-low

## Operation
- Digit content:
  - d0 = hex glyph of shown value.
  - d1 = lives = popcount(led0..led3), shown as a hex glyph.
  - d2 = blank.
  - d3 = status glyph: 'C' counting, '-' stop, 'P' win, 'L' lose.
- Shown value:
  - state_in 0 or 1: live `counter`.
  - state_in 2 or 3: `held`.
  - `held` loads `counter` on every clock edge where state_in==1.
- Glyphs (active-low, bit6=g):
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
  - 'P'=0x0C, 'L'=0x47, '-'=0x3F, blank=0x7F.
- Blink:
  - Active when state_in==2, or when state_in==3 with led4==1.
  - When active: blink_cnt counts 0..BLINK_DIV-1; at wrap it returns to 0 and toggles blink_on.
  - When inactive: blink_cnt=0 and blink_on=1 on the next edge.
  - blink_on==0 forces an=4'b1111; seg and dp continue updating.
- dp: 0 only when d3 is selected and state_in==2; otherwise 1.
- Lose with led4==0 (lives remain): no blink; game returns to counting on its own.

## Timing
- Reset values (async, immediate): refresh_cnt=0, digit_idx=0, blink_cnt=0, blink_on=1, held=0, an=4'b1111, seg=0x7F, dp=1.
- refresh_cnt counts 0..REFRESH_DIV-1. At wrap, digit_idx advances 0→1→2→3→0.
- seg, an and dp are registered, one cycle after digit_idx/inputs.
  - First rising edge after reset release: an=4'b1110, showing d0.
  - Output for digit k holds exactly REFRESH_DIV cycles.
- Input to output latency is 1 clock for seg/an/dp, with no synchronisers; inputs come from the same clock domain.
- `held` updates one edge after state_in==1 is seen. On the stop→win/lose transition the value shown equals counter at the stop cycle.
- Simultaneous refresh wrap and blink toggle: both take effect on the same edge. `an` reflects the new blink_on and the new digit_idx together.
- Blink phase is not reset by digit rotation. Blink deactivation mid-phase restores visibility on the next edge.
- Reset mid-scan: outputs go to reset values asynchronously. The scan restarts at d0 on the first edge after release.
- counter wrap 15→0 during counting displays F then 0 with no blank cycle.

## Test plan
1. Use REFRESH_DIV=4, BLINK_DIV=8. Hold rst 3 cycles, release, with state_in=0, counter=5, led0..3=1111. Required:
   - an sequence 1110,1101,1011,0111 repeating, each held 4 cycles.
   - seg values, in order: 0x12 ('5'), 0x19 ('4'), 0x7F (blank), 0x46 ('C').
   - dp=1 throughout.
2. Stop capture: counter=9, pulse state_in=1 for 1 cycle, then state_in=2 and counter changes to 3. Required:
   - d0 shows 0x10 ('9'), not 0x30.
   - d3 shows 0x0C ('P') with dp=0.
   - an=1111 for 8-cycle windows, alternating with 8 cycles of normal scan.
3. Lose with lives left: state_in=3, led0..3=0111, led4=0. Required:
   - No blanking; d1=0x30 ('3'); d3=0x47 ('L').
4. Game over: state_in=3, led0..3=0000, led4=1. Required:
   - Blink active; d1=0x40 ('0').
   - Switch state_in to 0 mid-blank: an is non-1111 on the next edge.
5. Assert rst asynchronously mid-digit, between clock edges. Required:
   - an=1111, seg=0x7F, dp=1 immediately.
   - After release, held=0 and the scan restarts at d0.
6. Counting sweep: counter 0..15 at one step per REFRESH_DIV·4 cycles. Required:
   - d0 matches the glyph table for every value, including F (0x0E) followed by 0 (0x40).
